iter_div_unit: RTL and testbench

- Parametrised multi-cycle integer divider for the EXE stage.
- Replaces the single-cycle "/" and "%" divide path in the ALU.
- Radix-2 restoring algorithm: one quotient bit per cycle, signed or unsigned, quotient and remainder produced together.
- Valid/ready handshake on input and output, plus a cancel input so the pipeline can flush an in-flight divide on exception or branch flush.

---
 rtl/iter_div_unit.sv | 118 +++++++++++
 tb/tb_iter_div_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_div_unit.sv
// Multi-cycle radix-2 restoring divider: signed or unsigned, quotient and remainder together,
// valid/ready on both sides and a cancel input for pipeline flushes.
module iter_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy
);

  localparam int unsigned CntW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            qneg_q;
  logic            rneg_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;

  logic             accept;
  logic             src1_neg;
  logic             src2_neg;
  logic [WIDTH-1:0] src1_mag;
  logic [WIDTH-1:0] src2_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] rem_next;

  assign in_ready = (state_q == StIdle) | ((state_q == StDone) & out_ready);
  assign accept   = in_valid & in_ready & ~cancel;

  // Sign flags are masked by the mode, so unsigned operands pass through as raw magnitudes.
  assign src1_neg = div_signed & src1[WIDTH-1];
  assign src2_neg = div_signed & src2[WIDTH-1];
  assign src1_mag = src1_neg ? -src1 : src1;
  assign src2_mag = src2_neg ? -src2 : src2;

  assign shifted  = {rem_q, dvd_q[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs_q};
  assign qbit     = ~trial[WIDTH];
  // Either branch is below the divisor, so the partial remainder always fits WIDTH bits.
  assign rem_next = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign quotient  = quo_q;
  assign remainder = rmd_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else if (cancel) begin
      state_q <= StIdle;
    end else if (accept) begin
      cnt_q  <= CntW'(WIDTH - 1);
      qneg_q <= src1_neg ^ src2_neg;
      rneg_q <= src1_neg;
      rem_q  <= '0;
      dvd_q  <= src1_mag;
      dvs_q  <= src2_mag;
      if (src2 == '0) begin
        quo_q   <= '1;
        rmd_q   <= src1;
        state_q <= StDone;
      end else begin
        state_q <= StCalc;
      end
    end else begin
      case (state_q)
        StCalc: begin
          rem_q <= rem_next;
          dvd_q <= {dvd_q[WIDTH-2:0], qbit};
          if (cnt_q == '0) begin
            state_q <= StFix;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StFix: begin
          quo_q   <= qneg_q ? -dvd_q : dvd_q;
          rmd_q   <= rneg_q ? -rem_q : rem_q;
          state_q <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Directed bench for iter_div_unit (WIDTH = 32) with an expected-result queue.
module tb_iter_div_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         div_signed = 1'b0;
  logic         cancel = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         in_ready;
  logic         out_valid;
  logic         busy;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  int checks = 0;
  int passes = 0;
  logic [2*W-1:0] sb[$];

  iter_div_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .div_signed(div_signed),
    .src1      (src1),
    .src2      (src2),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit push);
    int n = 0;
    in_valid   = 1'b1;
    div_signed = sgn;
    src1       = a;
    src2       = b;
    #1;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_ready", in_ready, 1);
    if (push) sb.push_back({eq, er});
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic take(input string tag);
    logic [2*W-1:0] e;
    e = 'x;
    if (sb.size() != 0) e = sb.pop_front();
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_q"}, quotient, e[2*W-1:W]);
    check({tag, "_r"}, remainder, e[W-1:0]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    int seen;
    logic [2*W-1:0] e;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    resetn = 1'b1;
    tick();

    // Unsigned 100/7 with exact latency: low after edges 1..32, high after edge 33.
    issue(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
    wait_valid(n);
    check("lat_100_7", n, 33);
    take("u100_7");

    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b1);
    wait_valid(n);
    take("s_m7_2");
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b1);
    wait_valid(n);
    take("s_7_m2");
    issue(1'b0, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b1);
    wait_valid(n);
    take("u_fff9_2");
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1);
    wait_valid(n);
    take("s_min_m1");

    // Divide by zero goes straight to DONE on the accept edge.
    issue(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
    wait_valid(n);
    check("lat_div0_u", n, 0);
    take("u_div0");
    issue(1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, 1'b1);
    wait_valid(n);
    check("lat_div0_s", n, 0);
    take("s_div0");

    // Backpressure, then a back-to-back accept on the releasing edge.
    issue(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b1);
    wait_valid(n);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_q", quotient, 333);
      check("bp_r", remainder, 1);
      tick();
    end
    e = sb.pop_front();
    check("bp_final_q", quotient, e[2*W-1:W]);
    check("bp_final_r", remainder, e[W-1:0]);
    out_ready  = 1'b1;
    in_valid   = 1'b1;
    div_signed = 1'b0;
    src1       = 32'd50;
    src2       = 32'd5;
    #1;
    check("b2b_in_ready", in_ready, 1);
    sb.push_back({32'd10, 32'd0});
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("b2b_busy", busy, 1);
    check("b2b_no_valid", out_valid, 0);
    wait_valid(n);
    check("lat_b2b", n, 33);
    take("b2b_50_5");

    // Cancel in the 10th CALC cycle.
    issue(1'b0, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (9) tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_in_ready", in_ready, 1);
    check("cancel_busy", busy, 0);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      tick();
    end
    check("cancel_no_valid", seen, 0);
    issue(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b1);
    wait_valid(n);
    take("after_cancel_9_3");

    // Cancel alongside in_valid in IDLE must not start anything.
    in_valid = 1'b1;
    cancel   = 1'b1;
    src1     = 32'd5;
    src2     = 32'd1;
    tick();
    in_valid = 1'b0;
    cancel   = 1'b0;
    check("idle_cancel_busy", busy, 0);
    tick();
    check("idle_cancel_busy2", busy, 0);
    check("idle_cancel_valid", out_valid, 0);

    // Cancel in DONE drops the result even with out_ready low.
    issue(1'b0, 32'd20, 32'd4, 32'd0, 32'd0, 1'b0);
    wait_valid(n);
    check("done_cancel_pre", out_valid, 1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("done_cancel_valid", out_valid, 0);
    check("done_cancel_busy", busy, 0);

    // Asynchronous reset in the 20th CALC cycle.
    issue(1'b0, 32'd123456, 32'd7, 32'd0, 32'd0, 1'b0);
    repeat (19) tick();
    #3 resetn = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_q", quotient, 0);
    check("mid_rst_r", remainder, 0);
    #3 resetn = 1'b1;
    tick();
    issue(1'b1, 32'd1, 32'd1, 32'd1, 32'd0, 1'b1);
    wait_valid(n);
    take("after_rst_1_1");

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
